// File: rtl/bbox_track_ctrl.sv
// Frame-level SEARCH/TRACK/COAST controller for the skin-mask bounding-box unit.
// Validates, smooths and publishes the latched box once per end-of-frame.
module bbox_track_ctrl #(
    parameter int IMG_W        = 720,
    parameter int IMG_H        = 576,
    parameter int MIN_W        = 8,
    parameter int MIN_H        = 8,
    parameter int LOST_FRAMES  = 4,
    parameter int SMOOTH_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        vsync,
    input  logic [9:0]  bb_x_min,
    input  logic [9:0]  bb_x_max,
    input  logic [9:0]  bb_y_min,
    input  logic [9:0]  bb_y_max,
    output logic [9:0]  box_x_min,
    output logic [9:0]  box_x_max,
    output logic [9:0]  box_y_min,
    output logic [9:0]  box_y_max,
    output logic        track_valid,
    output logic        box_upd,
    output logic [3:0]  miss_cnt,
    output logic [15:0] frame_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_TRACK  = 2'd1,
        S_COAST  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_vsync_d;
    logic        r_pending;
    logic        r_upd;
    logic [9:0]  r_x_min, r_x_max, r_y_min, r_y_max;
    logic [3:0]  r_miss;
    logic [15:0] r_frame_cnt;

    logic        w_eof;
    logic        w_valid;
    logic [10:0] w_w, w_h;
    logic [9:0]  w_sx_min, w_sx_max, w_sy_min, w_sy_max;
    logic [9:0]  w_nx_min, w_nx_max, w_ny_min, w_ny_max;
    logic [3:0]  w_miss_nxt;
    logic        w_drop;

    // Empty-box encoding (min=IMG_*, max=0) never passes the ordering test.
    assign w_eof   = r_vsync_d & ~vsync & en;
    assign w_w     = {1'b0, bb_x_max} - {1'b0, bb_x_min} + 11'd1;
    assign w_h     = {1'b0, bb_y_max} - {1'b0, bb_y_min} + 11'd1;
    assign w_valid = (bb_x_max >= bb_x_min) && (bb_y_max >= bb_y_min) &&
                     (w_w >= 11'(MIN_W)) && (w_h >= 11'(MIN_H));

    function automatic logic [9:0] smooth(input logic [9:0] cur, input logic [9:0] raw);
        logic signed [10:0] d;
        logic signed [10:0] n;
        d = $signed({1'b0, raw}) - $signed({1'b0, cur});
        n = $signed({1'b0, cur}) + (d >>> SMOOTH_SHIFT);
        return n[9:0];
    endfunction

    assign w_sx_min = smooth(r_x_min, bb_x_min);
    assign w_sx_max = smooth(r_x_max, bb_x_max);
    assign w_sy_min = smooth(r_y_min, bb_y_min);
    assign w_sy_max = smooth(r_y_max, bb_y_max);

    // An axis whose smoothed extremes cross falls back to the raw box.
    assign w_nx_min = (w_sx_min > w_sx_max) ? bb_x_min : w_sx_min;
    assign w_nx_max = (w_sx_min > w_sx_max) ? bb_x_max : w_sx_max;
    assign w_ny_min = (w_sy_min > w_sy_max) ? bb_y_min : w_sy_min;
    assign w_ny_max = (w_sy_min > w_sy_max) ? bb_y_max : w_sy_max;

    assign w_miss_nxt = r_miss + 4'd1;
    assign w_drop     = (w_miss_nxt >= 4'(LOST_FRAMES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_SEARCH;
            r_vsync_d   <= 1'b0;
            r_pending   <= 1'b0;
            r_upd       <= 1'b0;
            r_x_min     <= '0;
            r_x_max     <= '0;
            r_y_min     <= '0;
            r_y_max     <= '0;
            r_miss      <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_vsync_d <= vsync;
            r_pending <= w_eof;
            r_upd     <= r_pending;
            if (w_eof) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            // Evaluation ignores en so a frame already latched always completes.
            if (r_pending) begin
                case (r_state)
                    S_SEARCH: begin
                        if (w_valid) begin
                            r_state <= S_TRACK;
                            r_x_min <= bb_x_min;
                            r_x_max <= bb_x_max;
                            r_y_min <= bb_y_min;
                            r_y_max <= bb_y_max;
                            r_miss  <= '0;
                        end
                    end
                    S_TRACK, S_COAST: begin
                        if (w_valid) begin
                            r_state <= S_TRACK;
                            r_x_min <= w_nx_min;
                            r_x_max <= w_nx_max;
                            r_y_min <= w_ny_min;
                            r_y_max <= w_ny_max;
                            r_miss  <= '0;
                        end else if (w_drop) begin
                            r_state <= S_SEARCH;
                            r_x_min <= '0;
                            r_x_max <= '0;
                            r_y_min <= '0;
                            r_y_max <= '0;
                            r_miss  <= '0;
                        end else begin
                            r_state <= S_COAST;
                            r_miss  <= w_miss_nxt;
                        end
                    end
                    default: begin
                        r_state <= S_SEARCH;
                        r_miss  <= '0;
                    end
                endcase
            end
        end
    end

    assign box_x_min   = r_x_min;
    assign box_x_max   = r_x_max;
    assign box_y_min   = r_y_min;
    assign box_y_max   = r_y_max;
    assign track_valid = (r_state != S_SEARCH);
    assign box_upd     = r_upd;
    assign miss_cnt    = r_miss;
    assign frame_cnt   = r_frame_cnt;
    assign state       = r_state;

endmodule

// File: tb/tb_bbox_track_ctrl.sv
// Bench for bbox_track_ctrl: frame table applied through a scoreboard queue,
// plus hand sequences for enable, reset-during-evaluation and frame counter wrap.
module tb_bbox_track_ctrl;

    localparam int W = 47;

    typedef struct {
        logic [9:0] x0, x1, y0, y1;
        logic [9:0] e_x0, e_x1, e_y0, e_y1;
        logic [1:0] e_st;
        logic [3:0] e_miss;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        vsync = 1'b0;
    logic [9:0]  bb_x_min = '0, bb_x_max = '0, bb_y_min = '0, bb_y_max = '0;
    logic [9:0]  box_x_min, box_x_max, box_y_min, box_y_max;
    logic        track_valid, box_upd;
    logic [3:0]  miss_cnt;
    logic [15:0] frame_cnt;
    logic [1:0]  state;

    logic [W-1:0] exp_q[$];
    int           n_total = 0;
    int           n_pass = 0;
    logic [15:0]  exp_fc = 16'd0;
    vec_t         tbl[17];

    bbox_track_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .vsync(vsync),
        .bb_x_min(bb_x_min), .bb_x_max(bb_x_max), .bb_y_min(bb_y_min), .bb_y_max(bb_y_max),
        .box_x_min(box_x_min), .box_x_max(box_x_max), .box_y_min(box_y_min), .box_y_max(box_y_max),
        .track_valid(track_valid), .box_upd(box_upd), .miss_cnt(miss_cnt),
        .frame_cnt(frame_cnt), .state(state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int x0, x1, y0, y1, ex0, ex1, ey0, ey1, st, m);
        vec_t v;
        v.x0 = 10'(x0); v.x1 = 10'(x1); v.y0 = 10'(y0); v.y1 = 10'(y1);
        v.e_x0 = 10'(ex0); v.e_x1 = 10'(ex1); v.e_y0 = 10'(ey0); v.e_y1 = 10'(ey1);
        v.e_st = 2'(st); v.e_miss = 4'(m);
        return v;
    endfunction

    function automatic logic [W-1:0] pack_exp(input vec_t v);
        return {v.e_x0, v.e_x1, v.e_y0, v.e_y1, v.e_st, (v.e_st != 2'd0), v.e_miss};
    endfunction

    function automatic logic [W-1:0] pack_act();
        return {box_x_min, box_x_max, box_y_min, box_y_max, state, track_valid, miss_cnt};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every box_upd consumes one expected result.
    always @(negedge clk) begin
        if (!rst && box_upd) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_upd: got box_upd=1 expected no update");
            end else begin
                chk("frame_result", pack_act(), exp_q.pop_front());
            end
        end
    end

    // mode 0: normal, 1: en falls at eof+1, 2: en low at eof, 3: rst at eof+1
    task automatic do_frame(input vec_t v, input int mode);
        @(negedge clk);
        bb_x_min = v.x0; bb_x_max = v.x1; bb_y_min = v.y0; bb_y_max = v.y1;
        vsync = 1'b1;
        if (mode == 2) en = 1'b0;
        @(negedge clk);
        vsync = 1'b0;
        if (mode < 2) exp_q.push_back(pack_exp(v));
        if (mode != 2) exp_fc = exp_fc + 16'd1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1 && mode == 1) en = 1'b0;
            if (k == 1 && mode == 3) begin
                rst = 1'b1;
                #1;
                exp_fc = 16'd0;
                chk("rst_mid_eval_outputs", pack_act(), '0);
                chk("rst_mid_eval_fcnt", W'(frame_cnt), W'(0));
            end
            chk($sformatf("upd_latency_k%0d", k), W'(box_upd), W'((k == 2) && (mode < 2)));
        end
        en = 1'b1;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk(720, 0, 576, 0,    0,   0,  0,   0, 0, 0);
        tbl[1]  = mk(720, 0, 576, 0,    0,   0,  0,   0, 0, 0);
        tbl[2]  = mk(720, 0, 576, 0,    0,   0,  0,   0, 0, 0);
        tbl[3]  = mk(100, 199, 50, 149, 100, 199, 50, 149, 1, 0);
        tbl[4]  = mk(140, 199, 50, 149, 110, 199, 50, 149, 1, 0);
        tbl[5]  = mk(140, 199, 50, 149, 117, 199, 50, 149, 1, 0);
        tbl[6]  = mk(140, 199, 50, 149, 122, 199, 50, 149, 1, 0);
        tbl[7]  = mk(122, 198, 40, 149, 122, 198, 47, 149, 1, 0);
        tbl[8]  = mk(720, 0, 576, 0,    122, 198, 47, 149, 2, 1);
        tbl[9]  = mk(720, 0, 576, 0,    122, 198, 47, 149, 2, 2);
        tbl[10] = mk(122, 198, 47, 149, 122, 198, 47, 149, 1, 0);
        tbl[11] = mk(720, 0, 576, 0,    122, 198, 47, 149, 2, 1);
        tbl[12] = mk(720, 0, 576, 0,    122, 198, 47, 149, 2, 2);
        tbl[13] = mk(720, 0, 576, 0,    122, 198, 47, 149, 2, 3);
        tbl[14] = mk(720, 0, 576, 0,    0,   0,  0,   0, 0, 0);
        tbl[15] = mk(10, 16, 20, 39,    0,   0,  0,   0, 0, 0);
        tbl[16] = mk(10, 17, 20, 27,    10,  17, 20,  27, 1, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", pack_act(), '0);
        chk("reset_upd", W'(box_upd), W'(0));
        chk("reset_fcnt", W'(frame_cnt), W'(0));

        for (int i = 0; i < 17; i++) begin
            do_frame(tbl[i], 0);
            if (i == 2) chk("fcnt_after_3", W'(frame_cnt), W'(3));
        end
        chk("fcnt_after_table", W'(frame_cnt), W'(exp_fc));

        do_frame(mk(10, 17, 20, 27, 10, 17, 20, 27, 1, 0), 1);

        do_frame(mk(720, 0, 576, 0, 0, 0, 0, 0, 0, 0), 2);
        chk("en_low_fcnt_held", W'(frame_cnt), W'(exp_fc));
        chk("en_low_state_held", pack_act(), pack_exp(mk(0, 0, 0, 0, 10, 17, 20, 27, 1, 0)));

        do_frame(mk(100, 199, 50, 149, 0, 0, 0, 0, 0, 0), 3);
        repeat (3) @(negedge clk);
        chk("after_rst_outputs", pack_act(), '0);
        chk("after_rst_fcnt", W'(frame_cnt), W'(exp_fc));

        @(negedge clk);
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        exp_fc = 16'hFFFF;
        do_frame(mk(720, 0, 576, 0, 0, 0, 0, 0, 0, 0), 0);
        chk("fcnt_wrap", W'(frame_cnt), W'(16'h0000));
        chk("fcnt_model", W'(frame_cnt), W'(exp_fc));

        repeat (4) @(negedge clk);
        chk("queue_drained", W'(exp_q.size()), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
